// File: rtl/seg_scan_capture.sv
// Receive side of a multiplexed 7-segment bus: settles, inverse-decodes and frames digits.
// Optional CHANGE_ONLY_EN: present a completed frame only if it differs from the last one presented.
module seg_scan_capture #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [6:0]                seg_in,
  input  logic [NUM_DIGITS-1:0]     dig_sel_n,
  output logic [4*NUM_DIGITS-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      pat_err,
  output logic                      sel_err,
  output logic                      overrun,
  input  logic                      clr_err
);

  localparam int unsigned FRAME_W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_HOLD
  } state_e;

  state_e                 state_q, state_d;
  logic [6:0]             seg_s1_q, seg_s2_q, seg_p_q;
  logic [NUM_DIGITS-1:0]  sel_s1_q, sel_s2_q, sel_p_q;
  logic [NUM_DIGITS-1:0]  hold_sel_q, hold_sel_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_W-1:0]     slot_q, slot_d;
  logic [NUM_DIGITS-1:0]  mask_q, mask_d;
  logic [FRAME_W-1:0]     out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   pat_err_q, pat_err_d;
  logic                   sel_err_q, sel_err_d;
  logic                   overrun_q, overrun_d;
`ifdef CHANGE_ONLY_EN
  logic [FRAME_W-1:0]     last_q, last_d;
  logic                   has_last_q, has_last_d;
`endif

  logic [NUM_DIGITS-1:0]  sel_act;
  logic [NUM_DIGITS-1:0]  cap_act;
  logic                   any_sel;
  logic                   stable;
  logic                   one_hot;
  logic [4:0]             dec;
  logic                   dup;
  logic                   pat_set, sel_set, ovr_set;

  // Returns {valid, nibble} for an active-low g..a pattern.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'h10;
      7'b1111001: decode = 5'h11;
      7'b0100100: decode = 5'h12;
      7'b0110000: decode = 5'h13;
      7'b0011001: decode = 5'h14;
      7'b0010010: decode = 5'h15;
      7'b0000010: decode = 5'h16;
      7'b1111000: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0010000: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b0000011: decode = 5'h1B;
      7'b1000110: decode = 5'h1C;
      7'b0100001: decode = 5'h1D;
      7'b0000110: decode = 5'h1E;
      7'b0001110: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  // Synchroniser plus one-cycle-delayed copy for change detection; idle bus level is all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      seg_p_q  <= '1;
      sel_s1_q <= '1;
      sel_s2_q <= '1;
      sel_p_q  <= '1;
    end else begin
      seg_s1_q <= seg_in;
      seg_s2_q <= seg_s1_q;
      seg_p_q  <= seg_s2_q;
      sel_s1_q <= dig_sel_n;
      sel_s2_q <= sel_s1_q;
      sel_p_q  <= sel_s2_q;
    end
  end

  // In CAPTURE the delayed copy still holds the values that were stable through SETTLE.
  assign sel_act = ~sel_s2_q;
  assign cap_act = ~sel_p_q;
  assign any_sel = |sel_act;
  assign stable  = (seg_s2_q == seg_p_q) && (sel_s2_q == sel_p_q);
  assign one_hot = (cap_act != '0) && ((cap_act & (cap_act - NUM_DIGITS'(1))) == '0);
  assign dec     = decode(seg_p_q);

`ifdef CHANGE_ONLY_EN
  assign dup = has_last_q && (slot_q == last_q);
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_sel_d  = hold_sel_q;
    slot_d      = slot_q;
    mask_d      = mask_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    pat_set     = 1'b0;
    sel_set     = 1'b0;
    ovr_set     = 1'b0;
`ifdef CHANGE_ONLY_EN
    last_d      = last_q;
    has_last_d  = has_last_q;
`endif

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Frame completion runs before the capture write so a same-cycle capture survives the clear.
    if (&mask_q) begin
      mask_d = '0;
      if (!dup) begin
        if (!out_valid_q || out_ready) begin
          out_data_d  = slot_q;
          out_valid_d = 1'b1;
`ifdef CHANGE_ONLY_EN
          last_d      = slot_q;
          has_last_d  = 1'b1;
`endif
        end else begin
          ovr_set = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (any_sel) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (!any_sel) begin
          state_d = S_IDLE;
        end else if (!stable) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        state_d    = S_HOLD;
        hold_sel_d = sel_p_q;
        if (!one_hot) begin
          sel_set = 1'b1;
        end else if (!dec[4]) begin
          pat_set = 1'b1;
        end else begin
          for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (cap_act[i]) begin
              slot_d[4*i +: 4] = dec[3:0];
              mask_d[i]        = 1'b1;
            end
          end
        end
      end
      S_HOLD: begin
        if (!any_sel) begin
          state_d = S_IDLE;
        end else if (sel_s2_q != hold_sel_q) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clear wins over a same-cycle set.
    pat_err_d = clr_err ? 1'b0 : (pat_err_q | pat_set);
    sel_err_d = clr_err ? 1'b0 : (sel_err_q | sel_set);
    overrun_d = clr_err ? 1'b0 : (overrun_q | ovr_set);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hold_sel_q  <= '1;
      slot_q      <= '0;
      mask_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      pat_err_q   <= 1'b0;
      sel_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef CHANGE_ONLY_EN
      last_q      <= '0;
      has_last_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_sel_q  <= hold_sel_d;
      slot_q      <= slot_d;
      mask_q      <= mask_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      pat_err_q   <= pat_err_d;
      sel_err_q   <= sel_err_d;
      overrun_q   <= overrun_d;
`ifdef CHANGE_ONLY_EN
      last_q      <= last_d;
      has_last_q  <= has_last_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign pat_err   = pat_err_q;
  assign sel_err   = sel_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: table of full-frame scans plus hand-written corner sequences.
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel_n;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        pat_err;
  logic        sel_err;
  logic        overrun;
  logic        clr_err;

  int          n_chk = 0;
  int          n_fail = 0;
  int          acc_cnt = 0;
  logic [15:0] acc_last = '0;
  int          a0;

  typedef struct {
    logic [15:0] frame;
    logic        ready;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_ovr;
    int          exp_acc;
    logic        pulse;
  } vec_t;

  vec_t tbl[7];

  seg_scan_capture #(.NUM_DIGITS(4), .SETTLE_CYC(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .dig_sel_n (dig_sel_n),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pat_err   (pat_err),
    .sel_err   (sel_err),
    .overrun   (overrun),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  // Count accepted frames and remember the last accepted payload.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      acc_cnt  <= acc_cnt + 1;
      acc_last <= out_data;
    end
  end

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'b1000000;
      4'h1: enc = 7'b1111001;
      4'h2: enc = 7'b0100100;
      4'h3: enc = 7'b0110000;
      4'h4: enc = 7'b0011001;
      4'h5: enc = 7'b0010010;
      4'h6: enc = 7'b0000010;
      4'h7: enc = 7'b1111000;
      4'h8: enc = 7'b0000000;
      4'h9: enc = 7'b0010000;
      4'hA: enc = 7'b0001000;
      4'hB: enc = 7'b0000011;
      4'hC: enc = 7'b1000110;
      4'hD: enc = 7'b0100001;
      4'hE: enc = 7'b0000110;
      default: enc = 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic blank(input int n);
    dig_sel_n = 4'b1111;
    seg_in    = 7'b1111111;
    cyc(n);
  endtask

  task automatic digit(input int i, input logic [3:0] n);
    dig_sel_n    = 4'b1111;
    dig_sel_n[i] = 1'b0;
    seg_in       = enc(n);
    cyc(8);
  endtask

  task automatic scan_frame(input logic [15:0] f);
    for (int i = 0; i < 4; i++) digit(i, f[4*i +: 4]);
    blank(6);
  endtask

  initial begin
    tbl[0] = '{16'hF0A5, 1'b1, 1'b0, 16'hF0A5, 1'b0, 1, 1'b0};
`ifdef CHANGE_ONLY_EN
    tbl[1] = '{16'hF0A6, 1'b0, 1'b1, 16'hF0A6, 1'b0, 0, 1'b0};
    tbl[2] = '{16'hF0A7, 1'b0, 1'b1, 16'hF0A6, 1'b1, 0, 1'b1};
    tbl[3] = '{16'h1234, 1'b1, 1'b0, 16'h1234, 1'b0, 1, 1'b0};
    tbl[4] = '{16'h1234, 1'b1, 1'b0, 16'h1234, 1'b0, 0, 1'b0};
    tbl[5] = '{16'h1234, 1'b1, 1'b0, 16'h1234, 1'b0, 0, 1'b0};
`else
    tbl[1] = '{16'hF0A5, 1'b0, 1'b1, 16'hF0A5, 1'b0, 0, 1'b0};
    tbl[2] = '{16'hF0A5, 1'b0, 1'b1, 16'hF0A5, 1'b1, 0, 1'b1};
    tbl[3] = '{16'h1234, 1'b1, 1'b0, 16'h1234, 1'b0, 1, 1'b0};
    tbl[4] = '{16'h1234, 1'b1, 1'b0, 16'h1234, 1'b0, 1, 1'b0};
    tbl[5] = '{16'h1234, 1'b1, 1'b0, 16'h1234, 1'b0, 1, 1'b0};
`endif
    tbl[6] = '{16'h1235, 1'b1, 1'b0, 16'h1235, 1'b0, 1, 1'b0};

    rst_n     = 1'b0;
    seg_in    = 7'b1111111;
    dig_sel_n = 4'b1111;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    cyc(2);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_errs", 32'({pat_err, sel_err, overrun}), 32'h0);
    rst_n = 1'b1;
    cyc(2);
    chk("post_rst_valid", 32'(out_valid), 32'h0);

    for (int r = 0; r < 7; r++) begin
      a0        = acc_cnt;
      out_ready = tbl[r].ready;
      scan_frame(tbl[r].frame);
      chk($sformatf("row%0d_valid", r), 32'(out_valid), 32'(tbl[r].exp_valid));
      chk($sformatf("row%0d_data", r), 32'(out_data), 32'(tbl[r].exp_data));
      chk($sformatf("row%0d_ovr", r), 32'(overrun), 32'(tbl[r].exp_ovr));
      chk($sformatf("row%0d_acc", r), 32'(acc_cnt - a0), 32'(tbl[r].exp_acc));
      chk($sformatf("row%0d_errs", r), 32'({pat_err, sel_err}), 32'h0);
      if (tbl[r].pulse) begin
        out_ready = 1'b1;
        clr_err   = 1'b1;
        cyc(1);
        clr_err   = 1'b0;
        chk($sformatf("row%0d_hs_valid", r), 32'(out_valid), 32'h0);
        chk($sformatf("row%0d_hs_ovr", r), 32'(overrun), 32'h0);
        chk($sformatf("row%0d_hs_acc", r), 32'(acc_cnt - a0), 32'(tbl[r].exp_acc + 1));
        chk($sformatf("row%0d_hs_data", r), 32'(acc_last), 32'(tbl[r].exp_data));
      end
    end

    // Digit 1 never settles: segment toggles every cycle.
    out_ready = 1'b1;
    a0        = acc_cnt;
    dig_sel_n = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      seg_in = (k % 2 == 0) ? enc(4'h4) : enc(4'h5);
      cyc(1);
    end
    blank(6);
    chk("unsettled_valid", 32'(out_valid), 32'h0);
    chk("unsettled_acc", 32'(acc_cnt - a0), 32'h0);
    digit(0, 4'h7);
    digit(2, 4'h9);
    digit(3, 4'hC);
    blank(6);
    chk("partial_acc", 32'(acc_cnt - a0), 32'h0);
    chk("partial_valid", 32'(out_valid), 32'h0);
    digit(1, 4'h4);
    blank(6);
    chk("complete_acc", 32'(acc_cnt - a0), 32'h1);
    chk("complete_data", 32'(acc_last), 32'hC947);
    chk("complete_errs", 32'({pat_err, sel_err, overrun}), 32'h0);

    // Blank pattern on digit 2 is invalid.
    a0        = acc_cnt;
    dig_sel_n = 4'b1011;
    seg_in    = 7'b1111111;
    cyc(8);
    blank(6);
    chk("pat_err_set", 32'(pat_err), 32'h1);
    chk("pat_err_acc", 32'(acc_cnt - a0), 32'h0);
    chk("pat_err_valid", 32'(out_valid), 32'h0);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    chk("pat_err_clr", 32'(pat_err), 32'h0);

    // Pending frame, then a two-hot select, then reset mid-frame.
    out_ready = 1'b0;
    scan_frame(16'h1357);
    chk("pend_valid", 32'(out_valid), 32'h1);
    chk("pend_data", 32'(out_data), 32'h1357);
    dig_sel_n = 4'b1100;
    seg_in    = enc(4'h3);
    cyc(8);
    blank(6);
    chk("sel_err_set", 32'(sel_err), 32'h1);
    digit(2, 4'h1);
    digit(3, 4'h1);
    blank(6);
    chk("sel_err_mask_ovr", 32'(overrun), 32'h0);
    chk("sel_err_valid_held", 32'(out_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_data", 32'(out_data), 32'h0);
    chk("midrst_errs", 32'({pat_err, sel_err, overrun}), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    out_ready = 1'b1;
    a0        = acc_cnt;
    digit(0, 4'h8);
    digit(1, 4'h6);
    blank(6);
    chk("after_rst_partial_acc", 32'(acc_cnt - a0), 32'h0);
    digit(2, 4'h4);
    digit(3, 4'h2);
    blank(6);
    chk("after_rst_acc", 32'(acc_cnt - a0), 32'h1);
    chk("after_rst_data", 32'(acc_last), 32'h2468);
    chk("after_rst_errs", 32'({pat_err, sel_err, overrun}), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive side of the multiplexed 7-segment display interface. Samples an active-low segment bus and active-low digit selects driven by a scanning display driver.
- Inverse-decodes each segment pattern to a 4-bit hex nibble and assembles a complete multi-digit frame.
- Presents each frame on a valid/ready output. Used for loopback self-test of the display path and for reading external 7-segment sources.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; frame width = 4*NUM_DIGITS.
- SETTLE_CYC, 4, consecutive stable cycles required before a digit is captured (min 1).
- CNT_W, 3, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYC.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- seg_in  input  7  segment lines a-g, bit 6=g .. bit 0=a, active-low (0 = lit).
- dig_sel_n  input  NUM_DIGITS  digit enables, active-low; bit i low selects digit i.
- out_data  output  4*NUM_DIGITS  captured frame; digit i in bits [4i+3:4i].
- out_valid  output  1  frame available.
- out_ready  input  1  consumer accepts the frame when high together with out_valid.
- pat_err  output  1  sticky; an unrecognised segment pattern was captured.
- sel_err  output  1  sticky; more than one digit select was active after settle.
- overrun  output  1  sticky; a frame completed while out_valid was high and out_ready was low.
- clr_err  input  1  synchronous clear of pat_err, sel_err and overrun.

Behaviour:
- Reset values: all outputs 0, capture mask 0, FSM in IDLE.
- seg_in and dig_sel_n pass through a 2-FF synchroniser. All logic below uses the synchronised copies, so input-to-capture latency = 2 + SETTLE_CYC + 1 cycles.
- Decode table (seg_in to nibble):
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7
  - 0000000=8, 0010000=9, 0001000=A, 0000011=B, 1000110=C, 0100001=D, 0000110=E, 0001110=F
  - Any other pattern, including blank 1111111, is invalid.
- FSM states:
  - IDLE: all selects inactive. Goes to SETTLE when any select is low; counter cleared.
  - SETTLE: counts while seg and select are unchanged from the previous cycle. Any change restarts the count at 0. All selects inactive returns to IDLE. When count reaches SETTLE_CYC-1, goes to CAPTURE.
  - CAPTURE (1 cycle), select not one-hot: set sel_err, write nothing.
  - CAPTURE (1 cycle), select one-hot, pattern invalid: set pat_err, write nothing.
  - CAPTURE (1 cycle), select one-hot, pattern valid: write the nibble into slot i and set mask[i]. A re-capture of the same slot overwrites it.
  - CAPTURE always goes to HOLD.
  - HOLD: waits for a select change. All inactive goes to IDLE; a different nonzero select goes to SETTLE.
- Frame completion: the cycle after the mask becomes all ones.
  - If out_valid is 0, or a handshake occurs in that same cycle: load out_data, set out_valid, clear the mask.
  - Otherwise: drop the frame, set overrun, clear the mask.
- Handshake: out_valid stays high and out_data is stable until out_valid and out_ready are both high. out_valid falls the following cycle unless a new frame loads on that edge.
- clr_err has priority over a same-cycle set; the error is lost.
- rst_n assertion at any time forces the reset values immediately. A partial frame is discarded.

Optional Feature:
- CHANGE_ONLY_EN defined:
  - A completed frame is presented only if it differs from the last frame presented since reset.
  - Identical frames are silently discarded and do not set overrun.
  - The first frame after reset is always presented.
- CHANGE_ONLY_EN undefined: every completed frame is presented as described above.

Test Plan:
- Scan digits 0..3 with patterns for 5, A, 0, F, holding each for 8 cycles, out_ready=1 -> one out_valid pulse with out_data=16'hF0A5; no error flags set.
- Repeat the same scan with out_ready=0 across two frames -> out_data stays 16'hF0A5, out_valid held high, overrun=1 after the second frame. Then out_ready=1 -> handshake completes and out_valid=0.
- Hold digit 1 for only SETTLE_CYC-1 stable cycles, with seg toggling each cycle -> no capture, mask bit 1 stays 0, no frame produced.
- Select digit 2 with seg=1111111 -> pat_err=1, no frame produced. Assert clr_err -> pat_err=0 the next cycle.
- dig_sel_n=4'b1100 held 8 cycles -> sel_err=1, mask unchanged. Assert rst_n=0 mid-frame, after 2 digits are captured -> all outputs 0 immediately. A later full scan yields exactly one frame.
- With CHANGE_ONLY_EN defined, scan 16'h1234 three times, then 16'h1235 -> exactly two frames presented: 16'h1234, then 16'h1235.
